// File: rtl/run_control_pkg.sv
// run_control_pkg: shared state encodings and PC width for the run/halt sequencer
package run_control_pkg;

    localparam int RC_PC_W = 12;

    typedef enum logic [1:0] {
        RC_HOLD = 2'd0,
        RC_HALT = 2'd1,
        RC_RUN  = 2'd2,
        RC_STEP = 2'd3
    } rc_state_t;

endpackage

// File: rtl/run_control_ret_counter.sv
// run_control_ret_counter: enable counter with async active-low clear, wraps modulo 2^W
module run_control_ret_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    // count one per enabled edge, wrapping from all-ones back to zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (en)
            count <= count + W'(1);
    end

endmodule

// File: rtl/run_control.sv
// run_control: run/halt/single-step sequencer producing the single commit enable for the core
module run_control
    import run_control_pkg::*;
#(
    parameter int PC_W     = RC_PC_W,
    parameter int STEP_W   = 8,
    parameter int RET_W    = 32,
    parameter int HOLD_CYC = 2,
    parameter bit BOOT_RUN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic [STEP_W-1:0] step_count,
    input  logic              bp_en,
    input  logic [PC_W-1:0]   bp_addr,
    input  logic [PC_W-1:0]   pc,
    output logic              core_en,
    output logic              halted,
    output logic              bp_hit,
    output logic [1:0]        state,
    output logic [RET_W-1:0]  retired
);

    localparam int HW = $clog2(HOLD_CYC) + 1;

    rc_state_t         cur, nxt;
    logic [HW-1:0]     hold_cnt;
    logic [STEP_W-1:0] remaining;
    logic              skip_bp, bp_match, leave_halt, executing;

    assign state = cur;

    // state register plus the flags that must change on the same edge as the state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur    <= RC_HOLD;
            halted <= 1'b0;
            bp_hit <= 1'b0;
        end else begin
            cur    <= nxt;
            halted <= (nxt == RC_HALT);
            if (leave_halt)
                bp_hit <= 1'b0;
            else if (executing && bp_match)
                bp_hit <= 1'b1;
        end
    end

    // next-state selection; HALT request priority is halt > step > run
    always_comb begin
        nxt = cur;
        case (cur)
            RC_HOLD: nxt = (hold_cnt == HW'(HOLD_CYC - 1)) ? (BOOT_RUN ? RC_RUN : RC_HALT) : RC_HOLD;
            RC_HALT: nxt = halt_req ? RC_HALT : step_req ? RC_STEP : run_req ? RC_RUN : RC_HALT;
            RC_RUN:  nxt = (halt_req || bp_match) ? RC_HALT : RC_RUN;
            RC_STEP: nxt = (halt_req || bp_match || (core_en && remaining == STEP_W'(1))) ? RC_HALT : RC_STEP;
        endcase
    end

    // combinational commit gate and breakpoint compare, no added latency on core_en
    always_comb begin
        executing  = (cur == RC_RUN) || (cur == RC_STEP);
        bp_match   = bp_en && (pc == bp_addr) && !skip_bp;
        core_en    = executing && !bp_match;
        leave_halt = (cur == RC_HALT) && (nxt != RC_HALT);
    end

    // boot hold counter, step budget and the one-shot breakpoint skip after resuming
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt  <= '0;
            remaining <= '0;
            skip_bp   <= 1'b0;
        end else begin
            if (cur == RC_HOLD)
                hold_cnt <= hold_cnt + HW'(1);
            if (cur == RC_HALT && nxt == RC_STEP)
                remaining <= (step_count == '0) ? STEP_W'(1) : step_count;
            else if (cur == RC_STEP && core_en)
                remaining <= remaining - STEP_W'(1);
            if (leave_halt)
                skip_bp <= 1'b1;
            else if (core_en)
                skip_bp <= 1'b0;
        end
    end

    run_control_ret_counter #(.W(RET_W)) u_ret (
        .clk   (clk),
        .reset (reset),
        .en    (core_en),
        .count (retired)
    );

endmodule
